// File: rtl/fp_cvt_fi_pipe.sv
// fp_cvt_fi_pipe: three-stage floating-point to integer converter.
// Source single or double; destination word or long, signed or unsigned.
// Stage 1 unpacks, stage 2 aligns and rounds, stage 3 saturates and raises NV/NX.
// A single global advance signal freezes every stage while the output is back-pressured.
module fp_cvt_fi_pipe #(
   parameter int XLEN  = 64,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      src,
   input  logic             src_dbl,
   input  logic             dst_long,
   input  logic             signed_ctrl,
   input  logic [2:0]       rm,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  result,
   output logic [4:0]       fflags,
   output logic [TAG_W-1:0] out_tag
);

   // Long results only exist on a 64-bit datapath.
   localparam logic LONG_OK = (XLEN == 64);

   localparam logic [2:0] RM_RNE = 3'd0;
   localparam logic [2:0] RM_RDN = 3'd2;
   localparam logic [2:0] RM_RUP = 3'd3;
   localparam logic [2:0] RM_RMM = 3'd4;

   logic advance;

   // ---------------- stage 1 registers ----------------
   logic               s1_valid_q, s1_valid_d;
   logic               s1_sign_q, s1_sign_d;
   logic               s1_nan_q, s1_nan_d;
   logic               s1_inf_q, s1_inf_d;
   logic signed [12:0] s1_exp_q, s1_exp_d;
   logic [52:0]        s1_sig_q, s1_sig_d;
   logic               s1_long_q, s1_long_d;
   logic               s1_sgn_q, s1_sgn_d;
   logic [2:0]         s1_rm_q, s1_rm_d;
   logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;

   // ---------------- stage 2 registers ----------------
   logic               s2_valid_q, s2_valid_d;
   logic               s2_sign_q, s2_sign_d;
   logic               s2_nan_q, s2_nan_d;
   logic               s2_inf_q, s2_inf_d;
   logic               s2_ovf_q, s2_ovf_d;
   logic [63:0]        s2_mag_q, s2_mag_d;
   logic               s2_nx_q, s2_nx_d;
   logic               s2_long_q, s2_long_d;
   logic               s2_sgn_q, s2_sgn_d;
   logic [TAG_W-1:0]   s2_tag_q, s2_tag_d;

   // ---------------- stage 3 (output) registers ----------------
   logic               s3_valid_q, s3_valid_d;
   logic [XLEN-1:0]    s3_res_q, s3_res_d;
   logic [4:0]         s3_ff_q, s3_ff_d;
   logic [TAG_W-1:0]   s3_tag_q, s3_tag_d;

   assign advance   = ~s3_valid_q | out_ready;
   assign in_ready  = advance;
   assign out_valid = s3_valid_q;
   assign result    = s3_res_q;
   assign fflags    = s3_ff_q;
   assign out_tag   = s3_tag_q;

   // ---------------- stage 1: unpack ----------------
   logic               u_sign, u_all1, u_exp_zero, u_nan, u_inf;
   logic [10:0]        u_exp_raw;
   logic [51:0]        u_frac;
   logic signed [12:0] u_bias, u_exp;

   // Field extraction and classification; single fraction is left-aligned into 52 bits.
   always_comb begin
      if (src_dbl) begin
         u_sign    = src[63];
         u_exp_raw = src[62:52];
         u_frac    = src[51:0];
         u_bias    = 13'sd1023;
         u_all1    = &src[62:52];
      end else begin
         u_sign    = src[31];
         u_exp_raw = {3'b000, src[30:23]};
         u_frac    = {src[22:0], 29'd0};
         u_bias    = 13'sd127;
         u_all1    = &src[30:23];
      end
      u_exp_zero = (u_exp_raw == 11'd0);
      u_nan      = u_all1 & (|u_frac);
      u_inf      = u_all1 & ~(|u_frac);
      // Subnormals use the minimum normal exponent and no implicit one.
      u_exp      = $signed({2'b00, (u_exp_zero ? 11'd1 : u_exp_raw)}) - u_bias;
   end

   // Stage 1 next state: load on advance, otherwise hold.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_sign_d  = s1_sign_q;
      s1_nan_d   = s1_nan_q;
      s1_inf_d   = s1_inf_q;
      s1_exp_d   = s1_exp_q;
      s1_sig_d   = s1_sig_q;
      s1_long_d  = s1_long_q;
      s1_sgn_d   = s1_sgn_q;
      s1_rm_d    = s1_rm_q;
      s1_tag_d   = s1_tag_q;
      if (advance) begin
         s1_valid_d = in_valid;
         s1_sign_d  = u_sign;
         s1_nan_d   = u_nan;
         s1_inf_d   = u_inf;
         s1_exp_d   = u_exp;
         s1_sig_d   = {~u_exp_zero, u_frac};
         s1_long_d  = dst_long & LONG_OK;
         s1_sgn_d   = signed_ctrl;
         s1_rm_d    = rm;
         s1_tag_d   = in_tag;
      end
   end

   // Stage 1 register bank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_nan_q   <= 1'b0;
         s1_inf_q   <= 1'b0;
         s1_exp_q   <= '0;
         s1_sig_q   <= '0;
         s1_long_q  <= 1'b0;
         s1_sgn_q   <= 1'b0;
         s1_rm_q    <= '0;
         s1_tag_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_sign_q  <= s1_sign_d;
         s1_nan_q   <= s1_nan_d;
         s1_inf_q   <= s1_inf_d;
         s1_exp_q   <= s1_exp_d;
         s1_sig_q   <= s1_sig_d;
         s1_long_q  <= s1_long_d;
         s1_sgn_q   <= s1_sgn_d;
         s1_rm_q    <= s1_rm_d;
         s1_tag_q   <= s1_tag_d;
      end
   end

   // ---------------- stage 2: align and round ----------------
   logic [127:0] a_shifted;
   logic [6:0]   a_sh_amt;
   logic         a_big, a_tiny, a_g, a_s, a_inc;
   logic [63:0]  a_mag;
   logic [64:0]  a_sum;

   // Significand sits with its MSB at weight 2^-1 in a 64.64 fixed-point word,
   // so a left shift by exp+1 (0..64) lands the integer part in the top half.
   always_comb begin
      a_big     = (s1_exp_q >= 13'sd64);
      a_tiny    = (s1_exp_q < -13'sd1);
      a_sh_amt  = s1_exp_q[6:0] + 7'd1;
      a_shifted = {64'd0, s1_sig_q, 11'd0} << a_sh_amt;
      a_mag     = a_shifted[127:64];
      a_g       = a_shifted[63];
      a_s       = |a_shifted[62:0];
      if (a_tiny) begin
         a_mag = '0;
         a_g   = 1'b0;
         a_s   = |s1_sig_q;
      end else if (a_big) begin
         a_mag = '0;
         a_g   = 1'b0;
         a_s   = 1'b0;
      end
      case (s1_rm_q)
         RM_RNE:  a_inc = a_g & (a_s | a_mag[0]);
         RM_RDN:  a_inc = s1_sign_q & (a_g | a_s);
         RM_RUP:  a_inc = ~s1_sign_q & (a_g | a_s);
         RM_RMM:  a_inc = a_g;
         default: a_inc = 1'b0;
      endcase
      a_sum = {1'b0, a_mag} + {64'd0, a_inc};
   end

   // Stage 2 next state: a carry out of the rounding add is an overflow.
   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_sign_d  = s2_sign_q;
      s2_nan_d   = s2_nan_q;
      s2_inf_d   = s2_inf_q;
      s2_ovf_d   = s2_ovf_q;
      s2_mag_d   = s2_mag_q;
      s2_nx_d    = s2_nx_q;
      s2_long_d  = s2_long_q;
      s2_sgn_d   = s2_sgn_q;
      s2_tag_d   = s2_tag_q;
      if (advance) begin
         s2_valid_d = s1_valid_q;
         s2_sign_d  = s1_sign_q;
         s2_nan_d   = s1_nan_q;
         s2_inf_d   = s1_inf_q;
         s2_ovf_d   = a_big | a_sum[64];
         s2_mag_d   = a_sum[63:0];
         s2_nx_d    = a_g | a_s;
         s2_long_d  = s1_long_q;
         s2_sgn_d   = s1_sgn_q;
         s2_tag_d   = s1_tag_q;
      end
   end

   // Stage 2 register bank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q <= 1'b0;
         s2_sign_q  <= 1'b0;
         s2_nan_q   <= 1'b0;
         s2_inf_q   <= 1'b0;
         s2_ovf_q   <= 1'b0;
         s2_mag_q   <= '0;
         s2_nx_q    <= 1'b0;
         s2_long_q  <= 1'b0;
         s2_sgn_q   <= 1'b0;
         s2_tag_q   <= '0;
      end else begin
         s2_valid_q <= s2_valid_d;
         s2_sign_q  <= s2_sign_d;
         s2_nan_q   <= s2_nan_d;
         s2_inf_q   <= s2_inf_d;
         s2_ovf_q   <= s2_ovf_d;
         s2_mag_q   <= s2_mag_d;
         s2_nx_q    <= s2_nx_d;
         s2_long_q  <= s2_long_d;
         s2_sgn_q   <= s2_sgn_d;
         s2_tag_q   <= s2_tag_d;
      end
   end

   // ---------------- stage 3: saturate and flags ----------------
   logic [63:0] t_pos_max, t_neg_lim, t_res, t_res_ext;
   logic        t_nv, t_nx;

   // Range check against the destination limits; t_neg_lim is the largest legal negative magnitude.
   always_comb begin
      if (s2_sgn_q) begin
         t_pos_max = s2_long_q ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h0000_0000_7FFF_FFFF;
      end else begin
         t_pos_max = s2_long_q ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      end
      t_neg_lim = s2_long_q ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
      t_nv      = 1'b0;
      t_nx      = 1'b0;
      t_res     = '0;
      if (s2_nan_q) begin
         t_res = t_pos_max;
         t_nv  = 1'b1;
      end else if (!s2_sign_q) begin
         if (s2_inf_q | s2_ovf_q | (s2_mag_q > t_pos_max)) begin
            t_res = t_pos_max;
            t_nv  = 1'b1;
         end else begin
            t_res = s2_mag_q;
            t_nx  = s2_nx_q;
         end
      end else if (s2_sgn_q) begin
         if (s2_inf_q | s2_ovf_q | (s2_mag_q > t_neg_lim)) begin
            t_res = 64'd0 - t_neg_lim;
            t_nv  = 1'b1;
         end else begin
            t_res = 64'd0 - s2_mag_q;
            t_nx  = s2_nx_q;
         end
      end else begin
         // Unsigned destination, negative source: only a value rounding to zero is legal.
         if (s2_inf_q | s2_ovf_q | (s2_mag_q != 64'd0)) begin
            t_nv = 1'b1;
         end else begin
            t_nx = s2_nx_q;
         end
      end
      // Word results are sign-extended from bit 31 whatever their signedness.
      t_res_ext = s2_long_q ? t_res : {{32{t_res[31]}}, t_res[31:0]};
   end

   // Stage 3 next state.
   always_comb begin
      s3_valid_d = s3_valid_q;
      s3_res_d   = s3_res_q;
      s3_ff_d    = s3_ff_q;
      s3_tag_d   = s3_tag_q;
      if (advance) begin
         s3_valid_d = s2_valid_q;
         s3_res_d   = t_res_ext[XLEN-1:0];
         s3_ff_d    = {t_nv, 3'b000, t_nx};
         s3_tag_d   = s2_tag_q;
      end
   end

   // Output register bank; reset forces the visible result, flags and tag to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3_valid_q <= 1'b0;
         s3_res_q   <= '0;
         s3_ff_q    <= '0;
         s3_tag_q   <= '0;
      end else begin
         s3_valid_q <= s3_valid_d;
         s3_res_q   <= s3_res_d;
         s3_ff_q    <= s3_ff_d;
         s3_tag_q   <= s3_tag_d;
      end
   end

endmodule
